// File: rtl/spi_master_v3.sv
// Single-clock SPI master with registered SCK, all four CPOL/CPHA modes, MSB/LSB-first
// ordering, a runtime half-period divider and one-hot active-low slave selects.
module spi_master_v3 #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_SS    = 4,
  parameter int SS_SEL_W  = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic                 lsb_first_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic [SS_SEL_W-1:0]  ss_sel_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [DATA_SIZE-1:0] txdata_i,
  output logic [DATA_SIZE-1:0] rxdata_o,
  output logic                 rx_valid_o,
  output logic                 buzy_o,
  output logic                 sck_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic [NUM_SS-1:0]    ss_o
);

  localparam int EDGES = 2 * DATA_SIZE;
  localparam int EW    = $clog2(EDGES + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [EW-1:0]          edge_q, edge_d;
  logic [DATA_SIZE-1:0]   tx_q, tx_d;
  logic [DATA_SIZE-1:0]   rx_q, rx_d;
  logic [DATA_SIZE-1:0]   rxdata_q, rxdata_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic [NUM_SS-1:0]      ss_q, ss_d;
  logic                   ready_q, ready_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   lsb_q, lsb_d;
  logic                   cnt_done;
  logic                   toggle;
  logic                   leading;
  logic [EW-1:0]          next_edge;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rxdata_d   = rxdata_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    toggle     = 1'b0;
    cnt_done   = (cnt_q == div_q);
    next_edge  = edge_q + 1'b1;
    leading    = next_edge[0];

    case (state_q)
      IDLE: begin
        sck_d = cpol_i;
        if (tx_valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = '0;
          edge_d  = '0;
          div_d   = clk_div_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          lsb_d   = lsb_first_i;
          rx_d    = '0;
          ss_d    = '1;
          for (int i = 0; i < NUM_SS; i++) begin
            if (int'(ss_sel_i) == i) ss_d[i] = 1'b0;
          end
          // CPHA=0 presents the first bit before the first SCK edge
          if (!cpha_i) begin
            mosi_d = lsb_first_i ? txdata_i[0] : txdata_i[DATA_SIZE-1];
            tx_d   = lsb_first_i ? (txdata_i >> 1) : (txdata_i << 1);
          end else begin
            tx_d = txdata_i;
          end
        end
      end
      SETUP: begin
        sck_d = cpol_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = XFER;
          toggle  = 1'b1;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          cnt_d = '0;
          if (edge_q == LAST_EDGE) state_d = HOLD;
          else                     toggle  = 1'b1;
        end
      end
      HOLD: begin
        sck_d = cpol_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          cnt_d      = '0;
          state_d    = GAP;
          ss_d       = '1;
          rxdata_d   = rx_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        sck_d = cpol_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sample on the mode's sampling edge, shift out on the other one
    if (toggle) begin
      edge_d = next_edge;
      sck_d  = ~sck_q;
      if (leading != cpha_q) begin
        rx_d = lsb_q ? {miso_i, rx_q[DATA_SIZE-1:1]} : {rx_q[DATA_SIZE-2:0], miso_i};
      end else if (!(!cpha_q && next_edge == LAST_EDGE)) begin
        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_SIZE-1];
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      end
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rxdata_q   <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
      ready_q    <= 1'b1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rxdata_q   <= rxdata_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      ready_q    <= ready_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
    end
  end

  assign tx_ready_o = ready_q;
  assign rxdata_o   = rxdata_q;
  assign rx_valid_o = rx_valid_q;
  assign buzy_o     = (state_q != IDLE);
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;
  assign ss_o       = ss_q;

endmodule
